// File: rtl/edge_det_multi.sv
// edge_det_multi: multi-channel edge detector for asynchronous level inputs.
//
// Each channel passes through a synchroniser and a glitch filter, then gets rise and fall
// detection. Edges that the channel's mode allows set a sticky event flag, which software
// clears. All flags are ORed into a single registered interrupt line.
//
// Optional feature: define EDGE_CNT_EN to add a saturating per-channel qualified-edge counter.
// Without it, edge_cnt_o is tied to zero and the port list stays the same.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   a_i           asynchronous level inputs, one per channel
//   mode_i        per-channel mode [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr_i         per-channel clear of sticky flag and counter (level)
//   rising_edge   1-cycle pulse on filtered 0->1 (ignores mode)
//   falling_edge  1-cycle pulse on filtered 1->0 (ignores mode)
//   event_o       sticky qualified-edge flags
//   irq_o         registered OR of event_o
//   edge_cnt_o    per-channel qualified-edge counts, channel i at [i*CNT_W +: CNT_W]
module edge_det_multi #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         a_i,
  input  logic [2*NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]         clr_i,
  output logic [NUM_CH-1:0]         rising_edge,
  output logic [NUM_CH-1:0]         falling_edge,
  output logic [NUM_CH-1:0]         event_o,
  output logic                      irq_o,
  output logic [NUM_CH*CNT_W-1:0]   edge_cnt_o
);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync_q;
  logic [NUM_CH-1:0]                  w_sync;
  logic [NUM_CH-1:0]                  r_filt_q, w_filt_d;
  logic [NUM_CH-1:0]                  r_rise_q, r_fall_q;
  logic [NUM_CH-1:0]                  w_qual;
  logic [NUM_CH-1:0]                  r_event_q, w_event_d;
  logic                               r_irq_q;

  // Synchroniser: stage 0 samples the pad, the last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync_q <= '0;
    end else begin
      r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], a_i};
    end
  end

  assign w_sync = r_sync_q[SYNC_STAGES-1];

  if (FILT_CYCLES == 0) begin : g_bypass
    assign w_filt_d = w_sync;
  end else begin : g_filt
    localparam int unsigned FcW    = $clog2(FILT_CYCLES + 1);
    localparam logic [FcW-1:0] FcLast = FcW'(FILT_CYCLES - 1);

    logic [NUM_CH-1:0][FcW-1:0] r_fcnt_q, w_fcnt_d;

    // Level only moves after FILT_CYCLES consecutive disagreeing cycles; any agreeing
    // cycle restarts the count, so shorter glitches vanish completely.
    always_comb begin
      w_filt_d = r_filt_q;
      w_fcnt_d = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_sync[i] != r_filt_q[i]) begin
          if (r_fcnt_q[i] == FcLast) begin
            w_filt_d[i] = w_sync[i];
          end else begin
            w_fcnt_d[i] = r_fcnt_q[i] + FcW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_fcnt_q <= '0;
      end else begin
        r_fcnt_q <= w_fcnt_d;
      end
    end
  end

  // Pulses are registered alongside the filtered level so they line up with its change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_filt_q <= '0;
      r_rise_q <= '0;
      r_fall_q <= '0;
    end else begin
      r_filt_q <= w_filt_d;
      r_rise_q <= w_filt_d & ~r_filt_q;
      r_fall_q <= ~w_filt_d & r_filt_q;
    end
  end

  always_comb begin
    w_qual = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_qual[i] = (r_rise_q[i] & mode_i[2*i]) | (r_fall_q[i] & mode_i[2*i+1]);
    end
  end

  // A clear coinciding with a new edge must not lose the edge, so set dominates.
  assign w_event_d = (r_event_q & ~clr_i) | w_qual;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_event_q <= '0;
      r_irq_q   <= 1'b0;
    end else begin
      r_event_q <= w_event_d;
      r_irq_q   <= |r_event_q;
    end
  end

  assign rising_edge  = r_rise_q;
  assign falling_edge = r_fall_q;
  assign event_o      = r_event_q;
  assign irq_o        = r_irq_q;

`ifdef EDGE_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt_q, w_cnt_d;

  // Clear restarts from the current qualified edge so a coincident edge counts as 1.
  always_comb begin
    w_cnt_d = r_cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (clr_i[i]) begin
        w_cnt_d[i] = CNT_W'(w_qual[i]);
      end else if (w_qual[i] && (r_cnt_q[i] != {CNT_W{1'b1}})) begin
        w_cnt_d[i] = r_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_q <= '0;
    end else begin
      r_cnt_q <= w_cnt_d;
    end
  end

  assign edge_cnt_o = r_cnt_q;
`else
  assign edge_cnt_o = '0;
`endif

endmodule

// File: tb/tb_edge_det_multi.sv
module tb_edge_det_multi;

  localparam int unsigned NumCh   = 8;
  localparam int unsigned CntW    = 3;
  localparam int unsigned CntMax  = (1 << CntW) - 1;
  localparam int unsigned Latency = 6; // drive at negedge n -> pulse sampled at negedge n+6

  typedef struct {
    int unsigned      cyc;
    logic [NumCh-1:0] rise;
    logic [NumCh-1:0] fall;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NumCh-1:0]      a_i;
  logic [2*NumCh-1:0]    mode_i;
  logic [NumCh-1:0]      clr_i;
  logic [NumCh-1:0]      rising_edge, falling_edge, event_o;
  logic                  irq_o;
  logic [NumCh*CntW-1:0] edge_cnt_o;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q[$];
  int unsigned exp_cnt[NumCh];
  logic [NumCh-1:0] mon_r, mon_f;

  edge_det_multi #(
    .NUM_CH     (NumCh),
    .SYNC_STAGES(2),
    .FILT_CYCLES(4),
    .CNT_W      (CntW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .mode_i      (mode_i),
    .clr_i       (clr_i),
    .rising_edge (rising_edge),
    .falling_edge(falling_edge),
    .event_o     (event_o),
    .irq_o       (irq_o),
    .edge_cnt_o  (edge_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: pulses expected this cycle come off the queue; anything else is spurious.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_r = '0;
      mon_f = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        if (exp_q[0].cyc < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL stale_expect: cycle %0d entry never matched (now %0d)", exp_q[0].cyc, cyc);
        end else begin
          mon_r = mon_r | exp_q[0].rise;
          mon_f = mon_f | exp_q[0].fall;
        end
        void'(exp_q.pop_front());
      end
      n_vec++;
      if (rising_edge !== mon_r) begin
        n_err++;
        $display("FAIL rising_edge @%0d: got %h want %h", cyc, rising_edge, mon_r);
      end
      n_vec++;
      if (falling_edge !== mon_f) begin
        n_err++;
        $display("FAIL falling_edge @%0d: got %h want %h", cyc, falling_edge, mon_f);
      end
    end
  end

  // Call at a negedge: schedules expected pulses and updates the counter model.
  task automatic drive_a(input logic [NumCh-1:0] v);
    logic [NumCh-1:0] r, f;
    r = v & ~a_i;
    f = ~v & a_i;
    if ((r | f) != '0) exp_q.push_back('{cyc + Latency, r, f});
    for (int c = 0; c < NumCh; c++) begin
      if ((r[c] && mode_i[2*c]) || (f[c] && mode_i[2*c+1])) begin
        if (exp_cnt[c] < CntMax) exp_cnt[c]++;
      end
    end
    a_i = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    a_i    = '1;
    mode_i = '0;
    clr_i  = '0;
    for (int c = 0; c < NumCh; c++) exp_cnt[c] = 0;
    wait_cyc(3);
    n_vec++;
    if (rising_edge !== '0) begin n_err++; $display("FAIL rst_rise: got %h want 00", rising_edge); end
    n_vec++;
    if (falling_edge !== '0) begin n_err++; $display("FAIL rst_fall: got %h want 00", falling_edge); end
    n_vec++;
    if (event_o !== '0) begin n_err++; $display("FAIL rst_event: got %h want 00", event_o); end
    n_vec++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    n_vec++;
    if (edge_cnt_o !== '0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", edge_cnt_o); end
    // Inputs already high at release still produce one rising edge after the normal latency.
    mon_en = 1'b1;
    exp_q.push_back('{cyc + Latency, {NumCh{1'b1}}, {NumCh{1'b0}}});
    reset = 1'b1;
    wait_cyc(9);
    n_vec++;
    if (event_o !== '0) begin n_err++; $display("FAIL rst_mode_off_event: got %h want 00", event_o); end
    n_vec++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL rst_mode_off_irq: got %b want 0", irq_o); end
    drive_a('0);
    wait_cyc(10);
    n_vec++;
    if (event_o !== '0) begin n_err++; $display("FAIL fall_mode_off_event: got %h want 00", event_o); end
  endtask

  task automatic test_rise_ch0;
    mode_i = 16'h0001;
    drive_a(a_i | 8'h01);
    wait_cyc(6);
    n_vec++;
    if (event_o[0] !== 1'b0) begin n_err++; $display("FAIL ch0_event_early: got %b want 0", event_o[0]); end
    wait_cyc(1);
    n_vec++;
    if (event_o[0] !== 1'b1) begin n_err++; $display("FAIL ch0_event_set: got %b want 1", event_o[0]); end
    n_vec++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL ch0_irq_early: got %b want 0", irq_o); end
    wait_cyc(1);
    n_vec++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL ch0_irq_set: got %b want 1", irq_o); end
    clr_i[0] = 1'b1;
    exp_cnt[0] = 0;
    wait_cyc(1);
    clr_i[0] = 1'b0;
    n_vec++;
    if (event_o[0] !== 1'b0) begin n_err++; $display("FAIL ch0_event_clr: got %b want 0", event_o[0]); end
    wait_cyc(1);
    n_vec++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL ch0_irq_clr: got %b want 0", irq_o); end
  endtask

  task automatic test_glitch_ch1;
    mode_i = 16'h0004;
    a_i[1] = 1'b1;          // 3-cycle glitch: no expectation pushed
    wait_cyc(3);
    a_i[1] = 1'b0;
    wait_cyc(12);
    n_vec++;
    if (event_o[1] !== 1'b0) begin n_err++; $display("FAIL ch1_glitch_event: got %b want 0", event_o[1]); end
    drive_a(a_i | 8'h02);   // 4 cycles: just long enough
    wait_cyc(4);
    drive_a(a_i & ~8'h02);
    wait_cyc(10);
    n_vec++;
    if (event_o[1] !== 1'b1) begin n_err++; $display("FAIL ch1_pass_event: got %b want 1", event_o[1]); end
    n_vec++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL ch1_pass_irq: got %b want 1", irq_o); end
    clr_i[1] = 1'b1;
    exp_cnt[1] = 0;
    wait_cyc(1);
    clr_i[1] = 1'b0;
    wait_cyc(1);
    n_vec++;
    if (event_o !== '0) begin n_err++; $display("FAIL ch1_clr_event: got %h want 00", event_o); end
  endtask

  task automatic test_toggle_ch2;
    mode_i = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      drive_a(a_i ^ 8'h04);
      wait_cyc(20);
    end
    n_vec++;
    if (event_o[2] !== 1'b1) begin n_err++; $display("FAIL ch2_event: got %b want 1", event_o[2]); end
`ifdef EDGE_CNT_EN
    n_vec++;
    if (edge_cnt_o[2*CntW +: CntW] !== CntW'(exp_cnt[2])) begin
      n_err++;
      $display("FAIL ch2_count: got %0d want %0d", edge_cnt_o[2*CntW +: CntW], exp_cnt[2]);
    end
`else
    n_vec++;
    if (edge_cnt_o !== '0) begin n_err++; $display("FAIL ch2_cnt_off: got %h want 0", edge_cnt_o); end
`endif
    clr_i[2] = 1'b1;
    exp_cnt[2] = 0;
    wait_cyc(1);
    clr_i[2] = 1'b0;
  endtask

  task automatic test_clr_race_ch3;
    mode_i = 16'h0040;
    clr_i[3] = 1'b1;
    drive_a(a_i | 8'h08);
    wait_cyc(6);
    n_vec++;
    if (event_o[3] !== 1'b0) begin n_err++; $display("FAIL ch3_event_early: got %b want 0", event_o[3]); end
    wait_cyc(1);
    clr_i[3] = 1'b0;
    exp_cnt[3] = 1;
    n_vec++;
    if (event_o[3] !== 1'b1) begin n_err++; $display("FAIL ch3_set_wins: got %b want 1", event_o[3]); end
    wait_cyc(1);
    n_vec++;
    if (event_o[3] !== 1'b1) begin n_err++; $display("FAIL ch3_event_hold: got %b want 1", event_o[3]); end
`ifdef EDGE_CNT_EN
    n_vec++;
    if (edge_cnt_o[3*CntW +: CntW] !== CntW'(exp_cnt[3])) begin
      n_err++;
      $display("FAIL ch3_count: got %0d want %0d", edge_cnt_o[3*CntW +: CntW], exp_cnt[3]);
    end
`endif
    clr_i[3] = 1'b1;
    exp_cnt[3] = 0;
    wait_cyc(1);
    clr_i[3] = 1'b0;
  endtask

  task automatic test_sat_ch4;
    mode_i = 16'h0300;
    for (int k = 0; k < 9; k++) begin
      drive_a(a_i ^ 8'h10);
      wait_cyc(12);
    end
    n_vec++;
    if (event_o !== 8'h10) begin n_err++; $display("FAIL ch4_event: got %h want 10", event_o); end
`ifdef EDGE_CNT_EN
    n_vec++;
    if (edge_cnt_o[4*CntW +: CntW] !== CntW'(exp_cnt[4])) begin
      n_err++;
      $display("FAIL ch4_saturate: got %0d want %0d", edge_cnt_o[4*CntW +: CntW], exp_cnt[4]);
    end
`else
    n_vec++;
    if (edge_cnt_o !== '0) begin n_err++; $display("FAIL ch4_cnt_off: got %h want 0", edge_cnt_o); end
`endif
  endtask

  task automatic test_back_to_back;
    mode_i = '1;
    clr_i  = '1;
    for (int c = 0; c < NumCh; c++) exp_cnt[c] = 0;
    wait_cyc(1);
    clr_i = '0;
    n_vec++;
    if (event_o !== '0) begin n_err++; $display("FAIL all_clr: got %h want 00", event_o); end
    drive_a(~a_i);
    wait_cyc(7);
    n_vec++;
    if (event_o !== '1) begin n_err++; $display("FAIL all_event: got %h want ff", event_o); end
    wait_cyc(1);
    n_vec++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL all_irq: got %b want 1", irq_o); end
    drive_a(~a_i);
    wait_cyc(10);
    for (int c = 0; c < NumCh; c++) begin
`ifdef EDGE_CNT_EN
      n_vec++;
      if (edge_cnt_o[c*CntW +: CntW] !== CntW'(exp_cnt[c])) begin
        n_err++;
        $display("FAIL all_count ch%0d: got %0d want %0d", c, edge_cnt_o[c*CntW +: CntW],
                 exp_cnt[c]);
      end
`else
      n_vec++;
      if (edge_cnt_o[c*CntW +: CntW] !== '0) begin
        n_err++;
        $display("FAIL all_cnt_off ch%0d: got %0d want 0", c, edge_cnt_o[c*CntW +: CntW]);
      end
`endif
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expect: got %0d entries left want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise_ch0();
    test_glitch_ch1();
    test_toggle_ch2();
    test_clr_race_ch3();
    test_sat_ch4();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
